// File: rtl/device_exec_unit.sv
// Sequencing/execute stage: four 8-bit registers, Z/C flags, one instruction per STEP_DIV+2 clocks.
// Defining EXEC_SINGLE_STEP_EN replaces the prescaler with one instruction per synchronised i_step rising edge.
module device_exec_unit #(
  parameter logic [23:0] STEP_DIV = 24'd10_000_000
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_run,
`ifdef EXEC_SINGLE_STEP_EN
  input  logic        i_step,
`endif
  input  logic [7:0]  i_pc,
  input  logic [31:0] i_instruction,
  input  logic [7:0]  i_in,
  output logic [7:0]  o_next_pc,
  output logic [7:0]  o_out,
  output logic        o_zero,
  output logic        o_carry,
  output logic        o_halted,
  output logic        o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_LDI  = 4'h1, OP_MOV  = 4'h2, OP_ADD  = 4'h3, OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5, OP_OR   = 4'h6, OP_XOR  = 4'h7, OP_ADDI = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9, OP_BRZ  = 4'hA, OP_BRNZ = 4'hB, OP_OUT = 4'hC;
  localparam logic [3:0] OP_IN   = 4'hD, OP_SHL  = 4'hE, OP_HALT = 4'hF;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  regs_q [4];
  logic [7:0]  regs_d [4];
  logic        zero_q, zero_d, carry_q, carry_d;
  logic [7:0]  out_q, out_d;
  logic        advance;

`ifdef EXEC_SINGLE_STEP_EN
  localparam logic [23:0] step_div_unused = STEP_DIV;
  logic step_s1_q, step_s2_q, step_s3_q;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      step_s3_q <= 1'b0;
    end else begin
      step_s1_q <= i_step;
      step_s2_q <= step_s1_q;
      step_s3_q <= step_s2_q;
    end
  end

  // Edges seen outside WAIT are simply not consumed by the FSM.
  assign advance = step_s2_q & ~step_s3_q;
`else
  localparam logic [23:0] RELOAD = (STEP_DIV == 24'd0) ? 24'd0 : STEP_DIV - 24'd1;
  logic [23:0] presc_q, presc_d;

  assign advance = (presc_q == 24'd0);

  always_comb begin
    presc_d = presc_q;
    if (state_q == S_WAIT && !advance) presc_d = presc_q - 24'd1;
    if (state_d == S_WAIT && state_q != S_WAIT) presc_d = RELOAD;
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) presc_q <= 24'd0;
    else         presc_q <= presc_d;
  end
`endif

  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [7:0] imm, a, b;
  logic       unused_ir_bits;

  assign op             = ir_q[31:28];
  assign rd             = ir_q[27:26];
  assign rs             = ir_q[25:24];
  assign imm            = ir_q[7:0];
  assign unused_ir_bits = ^ir_q[23:8];
  assign a              = regs_q[rd];
  assign b              = regs_q[rs];

  logic [7:0] res;
  logic       wr, c_new, taken, out_wr, halt;

  // Operands are read from registered values, so rd==rs sees pre-update data.
  always_comb begin
    res    = 8'h00;
    wr     = 1'b0;
    c_new  = carry_q;
    taken  = 1'b0;
    out_wr = 1'b0;
    halt   = 1'b0;
    case (op)
      OP_LDI:  begin res = imm;  wr = 1'b1; end
      OP_MOV:  begin res = b;    wr = 1'b1; end
      OP_ADD:  begin {c_new, res} = {1'b0, a} + {1'b0, b};   wr = 1'b1; end
      OP_SUB:  begin res = a - b; c_new = (a < b);           wr = 1'b1; end
      OP_AND:  begin res = a & b; c_new = 1'b0;              wr = 1'b1; end
      OP_OR:   begin res = a | b; c_new = 1'b0;              wr = 1'b1; end
      OP_XOR:  begin res = a ^ b; c_new = 1'b0;              wr = 1'b1; end
      OP_ADDI: begin {c_new, res} = {1'b0, a} + {1'b0, imm}; wr = 1'b1; end
      OP_JMP:  taken = 1'b1;
      OP_BRZ:  taken = zero_q;
      OP_BRNZ: taken = ~zero_q;
      OP_OUT:  out_wr = 1'b1;
      OP_IN:   begin res = i_in; wr = 1'b1; end
      OP_SHL:  begin res = {a[6:0], 1'b0}; c_new = a[7];     wr = 1'b1; end
      OP_HALT: halt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    regs_d    = regs_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    out_d     = out_q;
    o_next_pc = i_pc;
    case (state_q)
      S_IDLE: begin
        o_next_pc = 8'h00;
        if (i_run) state_d = S_WAIT;
      end
      S_WAIT:  if (advance) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = i_instruction;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Dropping i_run in this cycle cancels the instruction entirely.
        if (i_run) begin
          if (wr) begin
            regs_d[rd] = res;
            zero_d     = (res == 8'h00);
            carry_d    = c_new;
          end
          if (out_wr) out_d = a;
          if (halt) begin
            state_d = S_HALT;
          end else begin
            state_d   = S_WAIT;
            o_next_pc = taken ? imm : i_pc + 8'd1;
          end
        end
      end
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase
    if (!i_run) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q <= S_IDLE;
      ir_q    <= 32'h0;
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      regs_q  <= regs_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      out_q   <= out_d;
    end
  end

  assign o_out    = out_q;
  assign o_zero   = zero_q;
  assign o_carry  = carry_q;
  assign o_halted = (state_q == S_HALT);
  assign o_busy   = (state_q == S_WAIT) || (state_q == S_FETCH) || (state_q == S_EXEC);

endmodule
